ifetch_unit: RTL

- Instruction fetch stage. It owns the PC, issues word reads to instruction memory over a req/ack handshake, and presents one buffered instruction to the decode stage through a valid/ready handshake.
- It consumes branch-resolution results, using the same 4-bit branch-control code the decoder emits, to redirect the PC.
- It squashes wrong-path instructions, including one whose memory read is still in flight.
- It sits between instruction memory and the control decoder.

---
 rtl/ifetch_unit_pkg.sv | 19 +
 rtl/ifetch_unit_branch_target_calc.sv | 40 ++++
 rtl/ifetch_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the fetch stage: branch-control codes (common with the
// control decoder), default widths/reset PC and the fetch FSM state encoding.
package ifetch_unit_pkg;

  localparam int          CB_W_DEF     = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  localparam logic [3:0] CB_NONE = 4'd0;
  localparam logic [3:0] CB_BEQ  = 4'd1;
  localparam logic [3:0] CB_J    = 4'd2;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_branch_target_calc.sv
// Branch resolution: decides whether a resolved branch is taken and computes
// its target. Purely combinational; redir_valid gating is left to the caller.
module branch_target_calc
  import ifetch_unit_pkg::*;
#(
  parameter int CB_W = CB_W_DEF
) (
  input  logic [31:0]     redir_pc,
  input  logic [CB_W-1:0] redir_cb,
  input  logic            redir_zero,
  input  logic [25:0]     redir_imm,
  output logic            taken,
  output logic [31:0]     target
);

  logic [31:0] pc_plus4;
  logic [31:0] beq_off;

  assign pc_plus4 = redir_pc + 32'd4;
  assign beq_off  = {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = pc_plus4 + beq_off;
    case (redir_cb)
      CB_W'(CB_NONE): taken = 1'b0;
      CB_W'(CB_BEQ): begin
        taken  = redir_zero;
        target = pc_plus4 + beq_off;
      end
      CB_W'(CB_J): begin
        taken  = 1'b1;
        target = {pc_plus4[31:28], redir_imm, 2'b00};
      end
      // reserved codes never redirect
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem over req/ack and buffers one
// instruction for decode. Define IFETCH_PERF_EN to add fetch/stall counters.
//
// state | meaning
// ISSUE | raise imem_req for pc on the next edge
// WAIT  | request outstanding, capture data on ack
// HOLD  | instruction buffered, waiting for decode to accept
// DROP  | squashed request outstanding, discard data on ack
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          CB_W     = CB_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [31:0]     inst_pc,
  input  logic            redir_valid,
  input  logic [CB_W-1:0] redir_cb,
  input  logic            redir_zero,
  input  logic [31:0]     redir_pc,
  input  logic [25:0]     redir_imm
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  fetch_state_t state, state_d;

  logic [31:0] pc, pc_d;
  logic [31:0] addr_d, inst_d, inst_pc_d;
  logic        req_d, valid_d;
  logic        br_taken, taken, consume;
  logic [31:0] br_target;

  branch_target_calc #(.CB_W(CB_W)) u_btc (
    .redir_pc   (redir_pc),
    .redir_cb   (redir_cb),
    .redir_zero (redir_zero),
    .redir_imm  (redir_imm),
    .taken      (br_taken),
    .target     (br_target)
  );

  assign taken   = redir_valid & br_taken;
  assign consume = inst_valid & inst_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ISSUE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_ISSUE: state_d = taken ? ST_ISSUE : ST_WAIT;
      ST_WAIT: begin
        if (taken)         state_d = imem_ack ? ST_ISSUE : ST_DROP;
        else if (imem_ack) state_d = ST_HOLD;
      end
      ST_HOLD: if (taken || consume) state_d = ST_ISSUE;
      ST_DROP: if (imem_ack) state_d = ST_ISSUE;
      default: state_d = ST_ISSUE;
    endcase
  end

  always_comb begin
    req_d     = imem_req;
    addr_d    = imem_addr;
    pc_d      = pc;
    valid_d   = inst_valid;
    inst_d    = inst;
    inst_pc_d = inst_pc;
    case (state)
      ST_ISSUE: begin
        // a same-cycle redirect makes pc stale, so hold off the request
        if (!taken) begin
          req_d  = 1'b1;
          addr_d = pc;
        end
      end
      ST_WAIT: begin
        if (imem_ack) req_d = 1'b0;
        if (imem_ack && !taken) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc;
          valid_d   = 1'b1;
          pc_d      = pc + 32'd4;
        end
      end
      ST_HOLD: if (consume) valid_d = 1'b0;
      ST_DROP: if (imem_ack) req_d = 1'b0;
      default: ;
    endcase
    // imem_addr is untouched here so an outstanding request stays stable
    if (taken) begin
      pc_d    = br_target;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
    end else begin
      imem_req   <= req_d;
      imem_addr  <= addr_d;
      pc         <= pc_d;
      inst_valid <= valid_d;
      inst       <= inst_d;
      inst_pc    <= inst_pc_d;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (consume)               fetch_cnt <= fetch_cnt + 32'd1;
      if (imem_req && !imem_ack) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
